universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
- Parametrised successor to the team's 4-bit SISO shift register.
- WIDTH-bit register with per-cycle mode control: hold, shift left/right, rotate left/right, parallel load.
- Adds an autonomous N-bit shift sequencer with start/busy/done handshake, used for serialising and deserialising words toward slow serial peripherals.
- Both register ends are exposed serially, so SISO, SIPO, PISO and PIPO usage come from one block.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, $clog2(WIDTH+1), width of shift_len and the internal shift counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
mode  input  3  per-cycle operation select (IDLE state only)
sin_lsb  input  1  serial bit entering q[0] on left shift
sin_msb  input  1  serial bit entering q[WIDTH-1] on right shift
parallel_in  input  WIDTH  word captured on parallel load
start  input  1  pulse: begin auto-shift sequence
shift_len  input  CNT_W  number of auto-shift cycles, sampled with start
auto_dir  input  1  0 = left, 1 = right; sampled with start
auto_rot  input  1  1 = rotate instead of shift during sequence; sampled with start
q  output  WIDTH  register contents
serial_out_msb  output  1  q[WIDTH-1], combinational
serial_out_lsb  output  1  q[0], combinational
busy  output  1  high while sequencer is in SHIFT
done  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset (async, active-high): q=0, busy=0, done=0, counter=0, state=IDLE. Outputs take these values while reset is high, independent of clk.
- Latency: every register operation takes effect on q at the rising edge that samples the control. The serial outputs follow q with no extra delay.
- Mode encoding, applied only in IDLE:
  - 0 = hold.
  - 1 = shift left: q <= {q[WIDTH-2:0], sin_lsb}.
  - 2 = shift right: q <= {sin_msb, q[WIDTH-1:1]}.
  - 3 = rotate left.
  - 4 = rotate right.
  - 5 = load: q <= parallel_in.
  - 6, 7 = hold (reserved).
- Sequencer states are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 latches auto_dir and auto_rot.
  - Counter loads min(shift_len, WIDTH).
  - If the loaded length is >0, go to SHIFT. If shift_len=0, go directly to DONE with no shift.
  - start has priority over mode; no mode operation happens in the start cycle.
- SHIFT:
  - busy=1.
  - Each cycle performs one shift or rotate in the latched direction, using sin_lsb or sin_msb for shifts.
  - Counter decrements each cycle.
  - The cycle that shifts with counter==1 transitions to DONE.
  - An N-length sequence therefore occupies exactly N SHIFT cycles.
- DONE: busy=0, done=1 for exactly one cycle, then return to IDLE.
- Inputs ignored outside IDLE:
  - mode and start are ignored in SHIFT and DONE.
  - A start asserted in DONE is lost; the requester must wait for done to fall.
- Length clamp: shift_len > WIDTH is clamped to WIDTH.
- Reset mid-sequence: immediate return to IDLE with q=0, busy=0, done=0. A partial sequence does not produce a done pulse.
- Serial input timing: serial inputs are sampled on every shifting edge, both in mode shifts and in sequencer shifts. The feeder must present a new bit before each edge.

Test Plan:
- SISO compatibility (WIDTH=4): reset, then mode=1 with sin_lsb=1,0,1,1 on consecutive cycles → q=4'b1011 after 4 edges; serial_out_msb then reads 1,0,1,1 while shifting 4 more zeros; q=0 at the end.
- Load + rotate (WIDTH=8): mode=5 with parallel_in=8'hA5 → q=8'hA5 next edge; mode=3 once → 8'h4B; mode=4 twice → 8'hA5 then 8'hD2.
- Auto sequence: q=8'h81, start with shift_len=3, auto_dir=1, auto_rot=0, sin_msb=0 → busy high for exactly 3 cycles, q=8'h10, done pulses 1 cycle after busy falls; mode=5 applied during busy has no effect.
- Boundaries:
  - shift_len=0 → done one cycle after start, q unchanged, busy never high.
  - shift_len=15 with WIDTH=8 → exactly 8 busy cycles.
  - start together with mode=5 in IDLE → no load occurs.
- Reset mid-operation: assert reset asynchronously (between edges) during the 2nd SHIFT cycle of a 6-cycle sequence → q, busy, done drop to 0 immediately; no done pulse after release; a new start works normally.
- Auto rotate: q=8'h01, start with shift_len=8, auto_dir=0, auto_rot=1 → q returns to 8'h01 at done, and serial_out_msb is 1 exactly once during the sequence.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register: per-cycle mode control,
// serial inputs, parallel load word, sequencer handshake and the register view.
interface universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic [2:0]       mode;
  logic             sin_lsb;
  logic             sin_msb;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] shift_len;
  logic             auto_dir;
  logic             auto_rot;
  logic [WIDTH-1:0] q;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic             busy;
  logic             done;

  // Requester side: drives controls and data, observes register and status.
  modport master (
    output mode, sin_lsb, sin_msb, parallel_in, start, shift_len, auto_dir, auto_rot,
    input  q, serial_out_msb, serial_out_lsb, busy, done
  );

  // Register side.
  modport slave (
    input  mode, sin_lsb, sin_msb, parallel_in, start, shift_len, auto_dir, auto_rot,
    output q, serial_out_msb, serial_out_lsb, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with per-cycle mode control (hold,
// shift, rotate, load) and an autonomous N-step shift sequencer with a
// start/busy/done handshake. Both ends are exposed serially.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  universal_shift_register_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] word, word_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             dir_lat, dir_next;
  logic             rot_lat, rot_next;
  logic [CNT_W-1:0] len_clamped;

  // One step of the register: dir 0 = toward MSB, 1 = toward LSB; rot
  // recirculates the end bit instead of taking the serial input.
  function automatic logic [WIDTH-1:0] step_word(
    input logic [WIDTH-1:0] cur,
    input logic             dir,
    input logic             rot,
    input logic             in_lsb,
    input logic             in_msb
  );
    logic [WIDTH-1:0] res;
    if (!dir)
      res = {cur[WIDTH-2:0], (rot ? cur[WIDTH-1] : in_lsb)};
    else
      res = {(rot ? cur[0] : in_msb), cur[WIDTH-1:1]};
    return res;
  endfunction

  assign len_clamped = (bus.shift_len > LEN_MAX) ? LEN_MAX : bus.shift_len;

  // State, register word, counter and latched sequence direction/rotate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      word    <= '0;
      cnt     <= '0;
      dir_lat <= 1'b0;
      rot_lat <= 1'b0;
    end else begin
      state   <= state_next;
      word    <= word_next;
      cnt     <= cnt_next;
      dir_lat <= dir_next;
      rot_lat <= rot_next;
    end
  end

  // Next-state logic: mode operations in IDLE, start takes priority and
  // launches the sequencer; SHIFT steps until the counter runs out.
  always_comb begin
    state_next = state;
    word_next  = word;
    cnt_next   = cnt;
    dir_next   = dir_lat;
    rot_next   = rot_lat;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          dir_next   = bus.auto_dir;
          rot_next   = bus.auto_rot;
          cnt_next   = len_clamped;
          state_next = (len_clamped != '0) ? SHIFT : DONE;
        end else begin
          case (bus.mode)
            MODE_SHL:  word_next = step_word(word, 1'b0, 1'b0, bus.sin_lsb, bus.sin_msb);
            MODE_SHR:  word_next = step_word(word, 1'b1, 1'b0, bus.sin_lsb, bus.sin_msb);
            MODE_ROL:  word_next = step_word(word, 1'b0, 1'b1, bus.sin_lsb, bus.sin_msb);
            MODE_ROR:  word_next = step_word(word, 1'b1, 1'b1, bus.sin_lsb, bus.sin_msb);
            MODE_LOAD: word_next = bus.parallel_in;
            default:   word_next = word;
          endcase
        end
      end
      SHIFT: begin
        word_next = step_word(word, dir_lat, rot_lat, bus.sin_lsb, bus.sin_msb);
        cnt_next  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.q              = word;
  assign bus.serial_out_msb = word[WIDTH-1];
  assign bus.serial_out_lsb = word[0];
  assign bus.busy           = (state == SHIFT);
  assign bus.done           = (state == DONE);

endmodule
